ws2812_frame_ctrl: RTL and testbench



---
 rtl/ws2812_frame_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// Packet parser between the UART receiver and the WS2812 strip driver.
// Turns checksummed SYNC/CMD/payload/CHK frames into pixel-buffer writes and refresh requests.
module ws2812_frame_ctrl #(
  parameter int          NUM_LEDS     = 64,
  parameter int          ADDR_W       = 6,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 43500
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Strip_Busy,
  output logic              o_Pix_We,
  output logic [ADDR_W-1:0] o_Pix_Addr,
  output logic [23:0]       o_Pix_Data,
  output logic              o_Refresh,
  output logic              o_Err,
  output logic [2:0]        o_Err_Code,
  output logic              o_Busy,
  output logic [2:0]        o_Dbg_State
);

  // Handshake: i_Rx_DV is a single-cycle strobe, i_Rx_Byte is only meaningful
  // in that cycle, and there is no back-pressure, so bytes arriving while a
  // write/fill/show is in progress are dropped and reported as an overrun.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_PAYLOAD   = 3'd2,
    S_CHK       = 3'd3,
    S_WRITE     = 3'd4,
    S_FILL      = 3'd5,
    S_SHOW_WAIT = 3'd6
  } state_t;

  localparam logic [7:0]        CMD_SET  = 8'h01;
  localparam logic [7:0]        CMD_FILL = 8'h02;
  localparam logic [7:0]        CMD_SHOW = 8'h03;
  localparam logic [15:0]       TO_LAST  = 16'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(NUM_LEDS - 1);

  localparam logic [2:0] ERR_CMD     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_IDX     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q;
  logic [7:0]        chk_q;
  logic [31:0]       pay_q;
  logic [2:0]        pay_cnt_q;
  logic [15:0]       to_cnt_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [23:0]       pix_data_q;
  logic              err_q;
  logic [2:0]        err_code_q;

  logic              parsing;
  logic              timeout;
  logic              chk_ok;
  logic              idx_bad;
  logic [2:0]        pay_last;
  logic              err_set;
  logic [2:0]        err_code_d;

  assign parsing  = (state_q == S_CMD) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign timeout  = parsing && (to_cnt_q == TO_LAST);
  assign chk_ok   = (i_Rx_Byte == chk_q);
  assign idx_bad  = ({24'd0, pay_q[31:24]} >= 32'(NUM_LEDS));
  assign pay_last = (cmd_q == CMD_SET) ? 3'd3 : 3'd2;

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and error decode; a timeout wins over a byte in the same cycle
  always_comb begin
    state_d    = state_q;
    err_set    = 1'b0;
    err_code_d = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = S_CMD;
      end
      S_CMD: begin
        if (timeout) begin
          err_set = 1'b1; err_code_d = ERR_TIMEOUT; state_d = S_IDLE;
        end else if (i_Rx_DV) begin
          case (i_Rx_Byte)
            CMD_SET, CMD_FILL: state_d = S_PAYLOAD;
            CMD_SHOW:          state_d = S_CHK;
            default: begin
              err_set = 1'b1; err_code_d = ERR_CMD; state_d = S_IDLE;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (timeout) begin
          err_set = 1'b1; err_code_d = ERR_TIMEOUT; state_d = S_IDLE;
        end else if (i_Rx_DV && (pay_cnt_q == pay_last)) begin
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (timeout) begin
          err_set = 1'b1; err_code_d = ERR_TIMEOUT; state_d = S_IDLE;
        end else if (i_Rx_DV) begin
          if (!chk_ok) begin
            err_set = 1'b1; err_code_d = ERR_CHK; state_d = S_IDLE;
          end else if ((cmd_q == CMD_SET) && idx_bad) begin
            err_set = 1'b1; err_code_d = ERR_IDX; state_d = S_IDLE;
          end else if (cmd_q == CMD_SET) begin
            state_d = S_WRITE;
          end else if (cmd_q == CMD_FILL) begin
            state_d = S_FILL;
          end else begin
            state_d = S_SHOW_WAIT;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (i_Rx_DV) begin err_set = 1'b1; err_code_d = ERR_OVERRUN; end
      end
      S_FILL: begin
        if (pix_addr_q == ADDR_END) state_d = S_IDLE;
        if (i_Rx_DV) begin err_set = 1'b1; err_code_d = ERR_OVERRUN; end
      end
      S_SHOW_WAIT: begin
        if (!i_Strip_Busy) state_d = S_IDLE;
        if (i_Rx_DV) begin err_set = 1'b1; err_code_d = ERR_OVERRUN; end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: checksum, payload shift register, timeout counter, pixel outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cmd_q      <= 8'd0;
      chk_q      <= 8'd0;
      pay_q      <= 32'd0;
      pay_cnt_q  <= 3'd0;
      to_cnt_q   <= 16'd0;
      pix_addr_q <= '0;
      pix_data_q <= 24'd0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      err_q <= err_set;
      if (err_set) err_code_q <= err_code_d;

      if (parsing && !i_Rx_DV && !timeout) to_cnt_q <= to_cnt_q + 16'd1;
      else                                 to_cnt_q <= 16'd0;

      if ((state_q == S_CMD) && i_Rx_DV && !timeout) begin
        cmd_q     <= i_Rx_Byte;
        chk_q     <= i_Rx_Byte;
        pay_q     <= 32'd0;
        pay_cnt_q <= 3'd0;
      end

      // After SET the register holds {IDX,G,R,B}; after FILL its low 24 bits hold {G,R,B}
      if ((state_q == S_PAYLOAD) && i_Rx_DV && !timeout) begin
        pay_q     <= {pay_q[23:0], i_Rx_Byte};
        chk_q     <= chk_q ^ i_Rx_Byte;
        pay_cnt_q <= pay_cnt_q + 3'd1;
      end

      if ((state_q == S_CHK) && (state_d == S_WRITE)) begin
        pix_addr_q <= pay_q[ADDR_W+23:24];
        pix_data_q <= pay_q[23:0];
      end else if ((state_q == S_CHK) && (state_d == S_FILL)) begin
        pix_addr_q <= '0;
        pix_data_q <= pay_q[23:0];
      end else if ((state_q == S_FILL) && (state_d == S_FILL)) begin
        pix_addr_q <= pix_addr_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    o_Pix_We    = (state_q == S_WRITE) || (state_q == S_FILL);
    o_Refresh   = (state_q == S_SHOW_WAIT) && !i_Strip_Busy;
    o_Busy      = (state_q != S_IDLE);
    o_Pix_Addr  = pix_addr_q;
    o_Pix_Data  = pix_data_q;
    o_Err       = err_q;
    o_Err_Code  = err_code_q;
    o_Dbg_State = state_q;
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: set/fill/show packets, error causes, timeout and reset abort.
module tb_ws2812_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        strip_busy;
  logic        pix_we;
  logic [5:0]  pix_addr;
  logic [23:0] pix_data;
  logic        refresh;
  logic        err;
  logic [2:0]  err_code;
  logic        busy;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  ws2812_frame_ctrl dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .i_Strip_Busy (strip_busy),
    .o_Pix_We     (pix_we),
    .o_Pix_Addr   (pix_addr),
    .o_Pix_Data   (pix_data),
    .o_Refresh    (refresh),
    .o_Err        (err),
    .o_Err_Code   (err_code),
    .o_Busy       (busy),
    .o_Dbg_State  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one-cycle strobe; returns at the negedge after the sampling posedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int fill_bad;
    logic quiet;

    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; strip_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", pix_we, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_refresh", refresh, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // SET_PIXEL idx 3
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h02);
    chk("set_we", pix_we, 1);
    chk("set_addr", pix_addr, 3);
    chk("set_data", pix_data, 24'h102030);
    chk("set_err", err, 0);
    @(negedge clk);
    chk("set_we_off", pix_we, 0);
    chk("set_busy_off", busy, 0);
    chk("set_addr_hold", pix_addr, 3);
    chk("set_err2", err, 0);

    // FILL whole strip
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h80); send_byte(8'h7D);
    fill_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!(pix_we === 1'b1 && pix_addr === 6'(i) && pix_data === 24'hFF0080)) fill_bad++;
      @(negedge clk);
    end
    chk("fill_cycles", fill_bad, 0);
    chk("fill_we_off", pix_we, 0);
    chk("fill_busy_off", busy, 0);
    chk("fill_addr_hold", pix_addr, 63);

    // SHOW while strip busy; SYNC byte during the wait is an overrun
    strip_busy = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
    chk("show_wait_refresh", refresh, 0);
    chk("show_wait_busy", busy, 1);
    repeat (40) @(negedge clk);
    send_byte(8'hA5);
    chk("ovr_err", err, 1);
    chk("ovr_code", err_code, 5);
    @(negedge clk);
    chk("ovr_strobe", err, 0);
    quiet = 1'b1;
    repeat (56) begin
      if (refresh !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk("show_no_early_refresh", quiet, 1);
    strip_busy = 1'b0;
    #1;
    chk("show_refresh", refresh, 1);
    @(negedge clk);
    chk("show_refresh_off", refresh, 0);
    chk("show_busy_off", busy, 0);

    // Bad checksum
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h00);
    chk("chk_err", err, 1);
    chk("chk_code", err_code, 2);
    chk("chk_no_we", pix_we, 0);
    @(negedge clk);
    chk("chk_code_held", {err, err_code}, {1'b0, 3'd2});
    chk("chk_busy_off", busy, 0);

    // Unknown command
    send_byte(8'hA5); send_byte(8'h07);
    chk("cmd_err", {err, err_code}, {1'b1, 3'd1});
    chk("cmd_busy_off", busy, 0);

    // Index out of range
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h41);
    chk("idx_err", {err, err_code}, {1'b1, 3'd3});
    chk("idx_no_we", pix_we, 0);

    // Inter-byte timeout
    send_byte(8'hA5); send_byte(8'h01);
    n = 0;
    while (err !== 1'b1 && n < 50000) begin
      @(negedge clk);
      n++;
    end
    chk("to_seen", err, 1);
    chk("to_latency_ok", (n >= 43498 && n <= 43502), 1);
    chk("to_code", err_code, 4);
    chk("to_busy_off", busy, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("post_to_we", pix_we, 1);
    chk("post_to_addr", pix_addr, 5);
    chk("post_to_data", pix_data, 24'h010203);

    // Reset during FILL at address 10
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h0A);
    send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0F);
    repeat (10) @(negedge clk);
    chk("rf_we", pix_we, 1);
    chk("rf_addr10", pix_addr, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("rf_we_off", pix_we, 0);
    chk("rf_addr0", pix_addr, 0);
    chk("rf_data0", pix_data, 0);
    chk("rf_misc0", {refresh, err, err_code, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rf_still_off", pix_we, 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDB);
    chk("rf_set_we", pix_we, 1);
    chk("rf_set_addr", pix_addr, 7);
    chk("rf_set_data", pix_data, 24'hAABBCC);
    @(negedge clk);
    chk("rf_set_done", {pix_we, busy, err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
